gauss_frame_ctrl: RTL and testbench

Frame sequencer for the 3x3 Gaussian smoothing stage. It scans a source image held in a dual-port pixel memory in raster order and streams the pixels into the Gaussian window filter. It collects the filtered results after the filter's fixed latency and writes each interior result back to a destination image region. It reports completion to the top-level pipeline controller through a start/busy/done handshake.

---
 rtl/gauss_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_gauss_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer: raster-scans the source image into the 3x3 Gaussian filter and writes interior results back.
// Define GAUSS_CTRL_BORDER_ZERO_EN to add a CLEAR pass that zeroes the whole destination before the scan.
module gauss_frame_ctrl #(
   parameter int IMG_W    = 16,
   parameter int IMG_H    = 16,
   parameter int ADDR_W   = 10,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 256,
   parameter int FILT_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              pix_valid,
   output logic [7:0]        pix_data,
   input  logic [7:0]        flt_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int STAGES = 1 + FILT_LAT;
   localparam int RW     = $clog2(IMG_H);
   localparam int CW     = $clog2(IMG_W);
   localparam int DW     = $clog2(STAGES + 1);

`ifdef GAUSS_CTRL_BORDER_ZERO_EN
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;
   localparam int NW = $clog2(NPIX);
   logic [NW-1:0] clr_cnt;
   logic          clr_wr;
`else
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
`endif

   state_t            st, nxt;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [DW-1:0]     drn_cnt;
   logic              scan_rd, last_pix, interior;
   logic [ADDR_W-1:0] src_addr, ctr_addr;
   logic [STAGES:1]   vld_pipe;
   logic [ADDR_W-1:0] addr_pipe [1:STAGES];

   assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign interior = (row >= RW'(2)) && (col >= CW'(2));
   assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
   // Write target is the window centre, one row and one column behind the pixel just read.
   assign ctr_addr = ADDR_W'(DST_BASE) + (ADDR_W'(row) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                   + ADDR_W'(col) - ADDR_W'(1);

   always_comb begin
      nxt     = st;
      busy    = 1'b0;
      done    = 1'b0;
      scan_rd = 1'b0;
      case (st)
         S_IDLE: if (start) begin
`ifdef GAUSS_CTRL_BORDER_ZERO_EN
            nxt = S_CLEAR;
`else
            nxt = S_SCAN;
`endif
         end
`ifdef GAUSS_CTRL_BORDER_ZERO_EN
         S_CLEAR: begin
            busy = 1'b1;
            if (clr_cnt == NW'(NPIX - 1)) nxt = S_SCAN;
         end
`endif
         S_SCAN: begin
            busy    = 1'b1;
            scan_rd = !stall;
            if (!stall && last_pix) nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (drn_cnt == '0) nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            nxt  = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= S_IDLE;
         row       <= '0;
         col       <= '0;
         drn_cnt   <= '0;
         pix_valid <= 1'b0;
         vld_pipe  <= '0;
         for (int i = 1; i <= STAGES; i++) addr_pipe[i] <= '0;
      end else begin
         st        <= nxt;
         pix_valid <= scan_rd;
         if (scan_rd) begin
            if (col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= last_pix ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         // Drain holds STAGES+1 cycles so the last write retires before DONE.
         drn_cnt      <= (st == S_DRAIN) ? drn_cnt - DW'(1) : DW'(STAGES);
         vld_pipe[1]  <= scan_rd & interior;
         addr_pipe[1] <= ctr_addr;
         for (int i = 2; i <= STAGES; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   assign rd_en    = scan_rd;
   assign rd_addr  = scan_rd ? src_addr : '0;
   assign pix_data = rd_data;
   assign wr_data  = vld_pipe[STAGES] ? flt_data : '0;

`ifdef GAUSS_CTRL_BORDER_ZERO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) clr_cnt <= '0;
      else     clr_cnt <= (st == S_CLEAR) ? clr_cnt + NW'(1) : '0;
   end

   assign clr_wr  = (st == S_CLEAR);
   assign wr_en   = vld_pipe[STAGES] | clr_wr;
   assign wr_addr = clr_wr ? ADDR_W'(DST_BASE) + ADDR_W'(clr_cnt)
                  : (vld_pipe[STAGES] ? addr_pipe[STAGES] : '0);
`else
   assign wr_en   = vld_pipe[STAGES];
   assign wr_addr = vld_pipe[STAGES] ? addr_pipe[STAGES] : '0;
`endif

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Bench for gauss_frame_ctrl: pixel memory, 3x3 Gaussian filter model and a frame-level reference of the destination image.
module tb_gauss_frame_ctrl;
   localparam int W = 16, H = 16, AW = 10, SRC = 0, DST = 256, FL = 1;
   localparam int N = W * H;
   localparam int D = 1 + FL;
`ifdef GAUSS_CTRL_BORDER_ZERO_EN
   localparam int CLR = N;
`else
   localparam int CLR = 0;
`endif
   localparam int NWR    = (W - 2) * (H - 2) + CLR;
   localparam int BUDGET = 4 * N + 200;

   logic          clk = 1'b0;
   logic          rst, start, stall;
   logic          busy, done, rd_en, pix_valid, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [7:0]    rd_data = 8'h00, flt_data = 8'h00, pix_data, wr_data;

   logic [7:0] mem    [0:(1<<AW)-1];
   logic [7:0] img    [0:N-1];
   logic [7:0] stream [0:N-1];
   bit         stall_pat [0:4*N-1];
   logic [7:0] fill;
   logic       load_req, mon_clr;

   int cyc = 0, sidx = 0;
   int n_rd = 0, n_wr = 0, n_pv = 0, ord_err = 0, stl_err = 0, n_done = 0;
   int done_cyc = -1, rise_cyc = -1, first_rd = -1;
   logic busy_q = 1'b0, busy_at_done = 1'b0;
   int n_chk = 0, n_fail = 0;

   gauss_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SRC_BASE(SRC), .DST_BASE(DST), .FILT_LAT(FL)) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pix_valid(pix_valid), .pix_data(pix_data),
      .flt_data(flt_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int wt(input int i, input int j);
      return (i == 0 ? 2 : 1) * (j == 0 ? 2 : 1);
   endfunction

   // Filter attached to the stream: window over the last three rows of streamed pixels.
   function automatic logic [7:0] filt(input int k, input logic [7:0] cur);
      int r, c, s, idx;
      r = k / W; c = k % W; s = 0;
      if (r < 2 || c < 2) return 8'h00;
      for (int i = -1; i <= 1; i++)
         for (int j = -1; j <= 1; j++) begin
            idx = (r - 1 + i) * W + (c - 1 + j);
            s += wt(i, j) * int'((idx == k) ? cur : stream[idx]);
         end
      return 8'(s / 16);
   endfunction

   // Reference destination pixel computed straight from the source image.
   function automatic logic [7:0] exp_dst(input int a);
      int r, c, s;
      r = a / W; c = a % W; s = 0;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1)
         return (CLR != 0) ? 8'h00 : fill;
      for (int i = -1; i <= 1; i++)
         for (int j = -1; j <= 1; j++)
            s += wt(i, j) * int'(img[(r + i) * W + c + j]);
      return 8'(s / 16);
   endfunction

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (load_req)
         for (int a = 0; a < N; a++) begin
            mem[SRC + a] <= img[a];
            mem[DST + a] <= fill;
         end
      if (mon_clr) begin
         n_rd <= 0; n_wr <= 0; n_pv <= 0; ord_err <= 0; stl_err <= 0; n_done <= 0;
         done_cyc <= -1; rise_cyc <= -1; first_rd <= -1; busy_at_done <= 1'b0; sidx <= 0;
      end else begin
         if (busy && !busy_q) rise_cyc <= cyc;
         if (done) begin
            n_done <= n_done + 1; done_cyc <= cyc; busy_at_done <= busy;
         end
         if (rd_en) begin
            n_rd <= n_rd + 1;
            if (first_rd < 0) first_rd <= cyc;
            if (int'(rd_addr) != SRC + (n_rd % N)) ord_err <= ord_err + 1;
            if (stall) stl_err <= stl_err + 1;
            rd_data <= mem[rd_addr];
         end
         if (wr_en) begin
            n_wr <= n_wr + 1;
            mem[wr_addr] <= wr_data;
         end
         if (pix_valid) begin
            n_pv <= n_pv + 1;
            stream[sidx] <= pix_data;
            flt_data <= filt(sidx, pix_data);
            sidx <= (sidx == N - 1) ? 0 : sidx + 1;
         end
      end
      busy_q <= busy;
   end

   task automatic check_dst(input string tag);
      for (int a = 0; a < N; a++)
         chk($sformatf("%s_dst[%0d]", tag, a), mem[DST + a], exp_dst(a));
   endtask

   task automatic load_img(input int kind);
      for (int a = 0; a < N; a++)
         case (kind)
            0:       img[a] = 8'h80;
            1:       img[a] = (a == 5 * W + 5) ? 8'hFF : 8'h00;
            default: img[a] = 8'($urandom);
         endcase
      fill = 8'hAA;
      @(posedge clk); #1;
      load_req = 1'b1; mon_clr = 1'b1; stall = 1'b0;
      @(posedge clk); #1;
      load_req = 1'b0; mon_clr = 1'b0;
   endtask

   // smode: 0 none, 1 ten cycles at row 7 col 5, 2 random stalls during the scan.
   task automatic run_frame(input int kind, input int smode, input bit repulse, input bit hold);
      int len, cnt, t, jj, d1;
      bit ok;
      len = 0; cnt = 0;
      while (cnt < N) begin
         case (smode)
            1:       stall_pat[len] = (len >= 7 * W + 5) && (len < 7 * W + 15);
            2:       stall_pat[len] = ($urandom_range(0, 3) == 0) && (len < 3 * N);
            default: stall_pat[len] = 1'b0;
         endcase
         if (!stall_pat[len]) cnt++;
         len++;
      end
      load_img(kind);
      start = 1'b1; t = cyc;
      ok = 1'b0;
      for (int k = 0; k < BUDGET && !ok; k++) begin
         @(posedge clk); #1;
         jj = cyc - (t + 1 + CLR);
         start = hold;
         if (repulse && cyc == t + 50) start = 1'b1;
         stall = (jj >= 0 && jj < len) ? stall_pat[jj] : 1'($urandom);
         if (done_cyc >= 0) ok = 1'b1;
      end
      stall = 1'b0;
      if (!ok) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("busy_rise", rise_cyc, t + 1);
      chk("first_rd", first_rd, t + 1 + CLR);
      chk("done_lat", done_cyc - rise_cyc, CLR + len + D + 1);
      chk("busy_at_done", busy_at_done, 0);
      chk("n_done", n_done, 1);
      chk("n_rd", n_rd, N);
      chk("n_pv", n_pv, N);
      chk("n_wr", n_wr, NWR);
      chk("rd_order", ord_err, 0);
      chk("rd_in_stall", stl_err, 0);
      check_dst("f1");
      if (!hold) begin
         repeat (4) @(posedge clk);
         #1 chk("no_restart", rise_cyc, t + 1);
         return;
      end
      d1 = done_cyc; ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (rise_cyc > d1) ok = 1'b1;
      end
      chk("retrigger", ok ? rise_cyc : -1, d1 + 2);
      ok = 1'b0;
      for (int k = 0; k < BUDGET && !ok; k++) begin
         @(posedge clk); #1;
         if (done_cyc > d1) ok = 1'b1;
      end
      chk("f2_done_seen", ok, 1);
      chk("f2_done_lat", done_cyc - rise_cyc, CLR + N + D + 1);
      chk("f2_n_rd", n_rd, 2 * N);
      chk("f2_n_wr", n_wr, 2 * NWR);
      check_dst("f2");
   endtask

   task automatic reset_mid;
      int t;
      load_img(2);
      start = 1'b1; t = cyc;
      while (cyc < t + 100) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      mon_clr = 1'b1;
      @(posedge clk); #1;
      mon_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_wr", n_wr, 0);
      chk("post_rst_rd", n_rd, 0);
      chk("post_rst_busy", busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; stall = 1'b0; load_req = 1'b0; mon_clr = 1'b0; fill = 8'hAA;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_rd_en", rd_en, 0);
      chk("init_pix_valid", pix_valid, 0);
      chk("init_wr_en", wr_en, 0);
      chk("init_rd_addr", rd_addr, 0);
      chk("init_wr_addr", wr_addr, 0);
      chk("init_wr_data", wr_data, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_frame(0, 0, 1'b0, 1'b0);
      chk("flat_centre", mem[DST + 8 * W + 8], 8'h80);

      run_frame(1, 0, 1'b0, 1'b0);
      chk("imp_centre", mem[DST + 5 * W + 5], 8'h3F);
      chk("imp_edge_n", mem[DST + 4 * W + 5], 8'h1F);
      chk("imp_edge_w", mem[DST + 5 * W + 4], 8'h1F);
      chk("imp_diag_se", mem[DST + 6 * W + 6], 8'h0F);
      chk("imp_far", mem[DST + 9 * W + 9], 8'h00);

      run_frame(2, 1, 1'b0, 1'b0);
      run_frame(2, 2, 1'b1, 1'b0);
      reset_mid();
      run_frame(2, 0, 1'b0, 1'b0);
      run_frame(2, 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
